// File: rtl/psg_pkg.sv
// Shared types and constants for the PSG host-bus register interface.
package psg_pkg;

    localparam int COUNTER_BITS_DEFAULT = 10;

    typedef logic [1:0] chan_t;

    typedef enum logic {
        LATCH_TONE  = 1'b0,
        LATCH_ATTEN = 1'b1
    } latch_type_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bus_state_t;

    localparam chan_t      NOISE_CHAN   = 2'd3;
    localparam logic [3:0] ATTEN_SILENT = 4'hF;

    // Channel field of a latch byte
    function automatic chan_t byte_chan(input logic [7:0] b);
        return b[6:5];
    endfunction

    // Register-type field of a latch byte
    function automatic latch_type_t byte_type(input logic [7:0] b);
        return latch_type_t'(b[4]);
    endfunction

endpackage

// File: rtl/psg_ready_timer.sv
// Busy countdown after an accepted write. busy stays high while further
// busy cycles remain after the current one, so BUSY->IDLE lands on time.
module psg_ready_timer #(
    parameter int BUSY_CYCLES = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);

    localparam int CW = $clog2(BUSY_CYCLES + 1);

    logic [CW-1:0] cnt_r;

    // Load on start, count down to zero, then hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (start) begin
            cnt_r <= CW'(BUSY_CYCLES - 1);
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign busy = (cnt_r != '0);

endmodule

// File: rtl/psg_bus_controller.sv
// PSG host-bus controller: latch/data byte decode into tone, attenuation and
// noise registers, plus clk_en prescaler. Optional macro PSG_READY_HANDSHAKE_EN.
module psg_bus_controller
    import psg_pkg::*;
#(
    parameter int COUNTER_BITS = COUNTER_BITS_DEFAULT,
    parameter int BUSY_CYCLES  = 32,
    parameter int CLK_DIV      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr,
    input  logic [7:0]                data,
    output logic                      ready,
    output logic [3*COUNTER_BITS-1:0] tone_freq,
    output logic [15:0]               attenuation,
    output logic [2:0]                noise_control,
    output logic                      restart_noise,
    output logic                      clk_en
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic                    ready_s;
    logic                    accept_s;
    logic [COUNTER_BITS-1:0] tone_r [3];
    logic [3:0]              atten_r [4];
    logic [2:0]              noise_r;
    logic                    restart_r;
    chan_t                   latch_ch_r;
    latch_type_t             latch_type_r;
    logic [PW-1:0]           presc_r;
    logic                    clk_en_r;

`ifdef PSG_READY_HANDSHAKE_EN
    bus_state_t state_r;
    bus_state_t state_nxt_s;
    logic       start_s;
    logic       busy_s;

    // Handshake state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and timer start
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wr) begin
                    state_nxt_s = ST_BUSY;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (busy_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    psg_ready_timer #(
        .BUSY_CYCLES(BUSY_CYCLES)
    ) u_ready_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_s),
        .busy  (busy_s)
    );

    assign ready_s = (state_r == ST_IDLE);
`else
    assign ready_s = 1'b1;
`endif

    assign accept_s = wr & ready_s;

    // Byte decode into the register file; restart pulses on every noise write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) tone_r[i] <= '0;
            for (int i = 0; i < 4; i++) atten_r[i] <= ATTEN_SILENT;
            noise_r      <= 3'b000;
            restart_r    <= 1'b0;
            latch_ch_r   <= 2'd0;
            latch_type_r <= LATCH_TONE;
        end else begin
            restart_r <= 1'b0;
            if (accept_s) begin
                if (data[7]) begin
                    latch_ch_r   <= byte_chan(data);
                    latch_type_r <= byte_type(data);
                    if (byte_type(data) == LATCH_ATTEN) begin
                        atten_r[byte_chan(data)] <= data[3:0];
                    end else if (byte_chan(data) == NOISE_CHAN) begin
                        noise_r   <= data[2:0];
                        restart_r <= 1'b1;
                    end else begin
                        tone_r[byte_chan(data)][3:0] <= data[3:0];
                    end
                end else begin
                    if (latch_type_r == LATCH_ATTEN) begin
                        atten_r[latch_ch_r] <= data[3:0];
                    end else if (latch_ch_r == NOISE_CHAN) begin
                        noise_r   <= data[2:0];
                        restart_r <= 1'b1;
                    end else begin
                        tone_r[latch_ch_r][9:4] <= data[5:0];
                    end
                end
            end
        end
    end

    // Free-running prescaler; clk_en fires as the count wraps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_r  <= '0;
            clk_en_r <= 1'b0;
        end else if (presc_r == PW'(CLK_DIV - 1)) begin
            presc_r  <= '0;
            clk_en_r <= 1'b1;
        end else begin
            presc_r  <= presc_r + PW'(1);
            clk_en_r <= 1'b0;
        end
    end

    assign ready         = ready_s;
    assign tone_freq     = {tone_r[2], tone_r[1], tone_r[0]};
    assign attenuation   = {atten_r[3], atten_r[2], atten_r[1], atten_r[0]};
    assign noise_control = noise_r;
    assign restart_noise = restart_r;
    assign clk_en        = clk_en_r;

endmodule
